piso_stream: RTL

Parametrised, streaming parallel-in/serial-out converter with a one-word holding register. Words arrive on a valid/ready handshake and are shifted out as `LANES`-bit beats, MSB-first or LSB-first. The holding register allows back-to-back words with no idle beats. It sits between parallel datapath blocks and narrow serial links; `enable` provides per-beat stall control from the link side.

---
 rtl/piso_pkg.sv | 32 +++
 rtl/piso_hold_reg.sv | 62 ++++++
 rtl/piso_stream.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream parallel-in/serial-out converter.
package piso_pkg;

    // Shifter state: IDLE has no beat on the output, SHIFT presents a beat.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit n set means LANES == n is a supported beat width (1, 2, 4, 8).
    localparam logic [15:0] LANES_LEGAL = 16'h0116;

    // Widest parallel word the beat-select helper can address.
    localparam int MAX_WIDTH = 64;

    // Returns beat 'index' of 'word' in the low bits; the caller keeps the low
    // 'lanes' bits. MSB-first counts beats down from the top of the word.
    function automatic logic [7:0] beat_sel(input logic [63:0] word,
                                            input int unsigned width,
                                            input int unsigned lanes,
                                            input int unsigned index,
                                            input logic        msb_first);
        int unsigned shamt;
        if (msb_first) begin
            shamt = width - ((index + 32'd1) * lanes);
        end else begin
            shamt = index * lanes;
        end
        return 8'(word >> shamt);
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// Single-entry holding register in front of the shifter. It accepts a word
// whenever it is empty or is being drained on the same edge, so the shifter
// can be reloaded back-to-back without an idle beat.
module piso_hold_reg
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             drain,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_valid,
    output logic             hold_valid_next
);

    logic [WIDTH-1:0] hold_data_r;
    logic             hold_valid_r;
    logic             valid_next_s;
    logic             accept_s;

    // Ready depends on drain, which in turn depends on the link-side enable.
    assign in_ready        = !flush && (!hold_valid_r || drain);
    assign accept_s        = in_valid && in_ready;
    assign hold_data       = hold_data_r;
    assign hold_valid      = hold_valid_r;
    assign hold_valid_next = valid_next_s;

    // Next occupancy: flush wins, a new word refills even while draining.
    always_comb begin
        valid_next_s = hold_valid_r;
        if (flush) begin
            valid_next_s = 1'b0;
        end else if (accept_s) begin
            valid_next_s = 1'b1;
        end else if (drain) begin
            valid_next_s = 1'b0;
        end else begin
            valid_next_s = hold_valid_r;
        end
    end

    // Holding register storage; data only moves on an accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= '0;
        end else begin
            hold_valid_r <= valid_next_s;
            if (accept_s) begin
                hold_data_r <= in_data;
            end else begin
                hold_data_r <= hold_data_r;
            end
        end
    end

endmodule

// File: rtl/piso_stream.sv
// Streaming parallel-in/serial-out converter. Words enter through a one-deep
// holding register and leave as LANES-bit beats; enable stalls the current
// beat and flush aborts both the holding register and the shifter.
module piso_stream
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             enable,
    input  logic             flush,
    output logic [LANES-1:0] out,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    localparam int BEATS = WIDTH / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS);
    localparam logic [CW-1:0] ONE_CNT  = CW'(32'd1);

    if ((WIDTH % LANES) != 32'sd0 || BEATS < 32'sd1 || LANES > 32'sd8 ||
        !LANES_LEGAL[LANES[3:0]] || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $error("piso_stream: WIDTH must be a multiple of LANES, LANES in {1,2,4,8}, WIDTH <= 64");
    end

    state_t           state_r, state_n;
    logic [CW-1:0]    cnt_r, cnt_n;
    logic [WIDTH-1:0] sr_r, sr_n;
    logic [LANES-1:0] out_r, out_n;
    logic             out_valid_r, out_valid_n;
    logic             out_last_r, out_last_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;

    logic [WIDTH-1:0] hold_data_s;
    logic             hold_valid_s;
    logic             hold_valid_next_s;
    logic             drain_s;

    // Move the next beat to the bottom (LSB-first) or top (MSB-first) of sr.
    function automatic logic [WIDTH-1:0] shift_beat(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return w << LANES;
        end else begin
            return w >> LANES;
        end
    endfunction

    // The hold register empties into an idle shifter at once, or into a busy
    // shifter on the edge its last beat is consumed.
    assign drain_s = hold_valid_s &&
                     (state_r == IDLE || (enable && cnt_r == LAST_CNT));

    piso_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .drain           (drain_s),
        .hold_data       (hold_data_s),
        .hold_valid      (hold_valid_s),
        .hold_valid_next (hold_valid_next_s)
    );

    // Shifter next-state: load, advance, finish-and-reload, stall or flush.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        sr_n    = sr_r;
        out_n   = out_r;
        done_n  = 1'b0;
        if (flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            sr_n    = '0;
            out_n   = '0;
        end else if (state_r == IDLE) begin
            if (drain_s) begin
                state_n = SHIFT;
                cnt_n   = ONE_CNT;
                out_n   = LANES'(beat_sel(64'(hold_data_s), WIDTH, LANES, 32'd0, MSB_FIRST != 0));
                sr_n    = shift_beat(hold_data_s);
            end else begin
                state_n = IDLE;
            end
        end else if (!enable) begin
            state_n = SHIFT;
        end else if (cnt_r == LAST_CNT) begin
            done_n = 1'b1;
            if (hold_valid_s) begin
                state_n = SHIFT;
                cnt_n   = ONE_CNT;
                out_n   = LANES'(beat_sel(64'(hold_data_s), WIDTH, LANES, 32'd0, MSB_FIRST != 0));
                sr_n    = shift_beat(hold_data_s);
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
                sr_n    = '0;
                out_n   = '0;
            end
        end else begin
            cnt_n = cnt_r + ONE_CNT;
            out_n = LANES'(beat_sel(64'(sr_r), WIDTH, LANES, 32'd0, MSB_FIRST != 0));
            sr_n  = shift_beat(sr_r);
        end
        out_valid_n = (state_n == SHIFT);
        out_last_n  = (state_n == SHIFT) && (cnt_n == LAST_CNT);
        busy_n      = (state_n == SHIFT) || hold_valid_next_s;
    end

    // Shifter state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            sr_r        <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            sr_r        <= sr_n;
            out_r       <= out_n;
            out_valid_r <= out_valid_n;
            out_last_r  <= out_last_n;
            busy_r      <= busy_n;
            done_r      <= done_n;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
